// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: accepts a cipher key and fills an 11-entry
// round-key bank, one round key per clock, read through a combinational index port.
module aes_key_expand #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] key_in,
  input  logic         key_valid,
  output logic         key_ready,
  output logic         busy,
  output logic         keys_valid,
  input  logic [3:0]   rk_idx,
  output logic [127:0] rk_out
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } state_t;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      else      p = p;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  // S-box = affine transform of the GF(2^8) inverse; the inverse is a^254 (0 maps to 0).
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    case (rnd)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  state_t              state_q, state_d;
  logic [3:0]          round_q, round_d;
  logic [3:0][31:0]    w_q, w_d;
  logic [127:0]        rk_q [NR+1];
  logic                key_ready_q, key_ready_d;
  logic                busy_q, busy_d;
  logic                keys_valid_q, keys_valid_d;

  logic                wr_en_s;
  logic [3:0]          wr_idx_s;
  logic [127:0]        wr_data_s;
  logic [31:0]         rot_s, sub_s, t_s;
  logic [3:0][31:0]    n_s;

  // One round of the schedule from the current working words (w_q[3] is w0).
  always_comb begin
    rot_s = {w_q[0][23:0], w_q[0][31:24]};
    sub_s = {sbox(rot_s[31:24]), sbox(rot_s[23:16]), sbox(rot_s[15:8]), sbox(rot_s[7:0])};
    t_s   = sub_s ^ {rcon(round_q), 24'h000000};
    n_s[3] = w_q[3] ^ t_s;
    n_s[2] = w_q[2] ^ n_s[3];
    n_s[1] = w_q[1] ^ n_s[2];
    n_s[0] = w_q[0] ^ n_s[1];
  end

  // Next-state, bank write request and registered status flags.
  always_comb begin
    state_d   = state_q;
    round_d   = round_q;
    w_d       = w_q;
    wr_en_s   = 1'b0;
    wr_idx_s  = 4'd0;
    wr_data_s = 128'h0;
    case (state_q)
      IDLE, DONE: begin
        if (key_valid) begin
          wr_en_s   = 1'b1;
          wr_data_s = key_in;
          w_d       = key_in;
          round_d   = 4'd1;
          state_d   = EXPAND;
        end else begin
          state_d = state_q;
        end
      end
      EXPAND: begin
        wr_en_s   = 1'b1;
        wr_idx_s  = round_q;
        wr_data_s = n_s;
        w_d       = n_s;
        round_d   = round_q + 4'd1;
        if (round_q == 4'(NR)) state_d = DONE;
        else                   state_d = EXPAND;
      end
      default: state_d = IDLE;
    endcase
    key_ready_d  = (state_d != EXPAND);
    busy_d       = (state_d == EXPAND);
    keys_valid_d = (state_d == DONE);
  end

  // Control state, working words and status flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      round_q      <= 4'd0;
      w_q          <= '0;
      key_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      keys_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      round_q      <= round_d;
      w_q          <= w_d;
      key_ready_q  <= key_ready_d;
      busy_q       <= busy_d;
      keys_valid_q <= keys_valid_d;
    end
  end

  // Round-key bank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= NR; i++) rk_q[i] <= 128'h0;
    end else begin
      for (int i = 0; i <= NR; i++) begin
        if (wr_en_s && (wr_idx_s == 4'(i))) rk_q[i] <= wr_data_s;
      end
    end
  end

  // Index read; out-of-range selects return zero.
  always_comb begin
    rk_out = 128'h0;
    for (int i = 0; i <= NR; i++) begin
      if (rk_idx == 4'(i)) rk_out = rk_q[i];
      else                 rk_out = rk_out;
    end
  end

  assign key_ready  = key_ready_q;
  assign busy       = busy_q;
  assign keys_valid = keys_valid_q;

endmodule

// File: tb/tb_aes_key_expand.sv
// Self-checking bench for aes_key_expand: FIPS-197 vectors, random keys against a
// table-driven key-schedule model, protocol, rekey and asynchronous reset checks.
module tb_aes_key_expand;

  logic         clk;
  logic         rst;
  logic [127:0] key_in;
  logic         key_valid;
  logic         key_ready;
  logic         busy;
  logic         keys_valid;
  logic [3:0]   rk_idx;
  logic [127:0] rk_out;

  int err_cnt = 0;
  int chk_cnt = 0;
  logic [127:0] mdl_rk [11];

  logic [7:0] sb [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  aes_key_expand #(.NR(10)) dut (
    .clk        (clk),
    .rst        (rst),
    .key_in     (key_in),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .busy       (busy),
    .keys_valid (keys_valid),
    .rk_idx     (rk_idx),
    .rk_out     (rk_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // FIPS-197 key expansion over a 44-word array.
  task automatic model_expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h000000};
        rc = rc[7] ? ({rc[6:0], 1'b0} ^ 8'h1b) : {rc[6:0], 1'b0};
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) mdl_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic read_rk(input logic [3:0] idx);
    rk_idx = idx;
    #1;
  endtask

  task automatic run_key(input logic [127:0] key, input bit poke, input string tag);
    int cyc;
    bit ready_bad;
    @(negedge clk);
    key_in    = key;
    key_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    key_valid = 1'b0;
    key_in    = 128'h0;
    check_eq({tag, "_kv_low_after_accept"}, {127'h0, keys_valid}, 128'h0);
    cyc = 0;
    ready_bad = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (key_ready || !busy) ready_bad = 1'b1;
      if (poke && k == 3) begin
        key_valid = 1'b1;
        key_in    = ~key;
      end else begin
        key_valid = 1'b0;
        key_in    = 128'h0;
      end
      @(posedge clk);
      @(negedge clk);
      if (keys_valid) begin
        cyc = k;
        break;
      end
    end
    key_valid = 1'b0;
    check_eq({tag, "_latency"}, 128'(cyc), 128'd10);
    check_eq({tag, "_ready_low_in_expand"}, {127'h0, ready_bad}, 128'h0);
    check_eq({tag, "_done_flags"}, {125'h0, key_ready, busy, keys_valid}, 128'h5);
    model_expand(key);
    for (int r = 0; r < 11; r++) begin
      read_rk(4'(r));
      check_eq($sformatf("%s_rk%0d", tag, r), rk_out, mdl_rk[r]);
    end
  endtask

  initial begin
    logic [127:0] rkey;
    rst = 1'b1;
    key_valid = 1'b0;
    key_in = 128'h0;
    rk_idx = 4'd0;
    #1;
    check_eq("reset_flags", {125'h0, key_ready, busy, keys_valid}, 128'h4);
    read_rk(4'd0);
    check_eq("reset_rk0", rk_out, 128'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_key(128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0, "fips");
    read_rk(4'd0);
    check_eq("fips_vec_rk0", rk_out, 128'h2b7e151628aed2a6abf7158809cf4f3c);
    read_rk(4'd1);
    check_eq("fips_vec_rk1", rk_out, 128'ha0fafe1788542cb123a339392a6c7605);
    read_rk(4'd10);
    check_eq("fips_vec_rk10", rk_out, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    for (int i = 11; i < 16; i++) begin
      read_rk(4'(i));
      check_eq($sformatf("idx_oob_%0d", i), rk_out, 128'h0);
    end

    run_key(128'h0, 1'b0, "rekey_zero");
    read_rk(4'd1);
    check_eq("zero_vec_rk1", rk_out, 128'h62636363626363636263636362636363);
    read_rk(4'd10);
    check_eq("zero_vec_rk10", rk_out, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    for (int n = 0; n < 4; n++) begin
      rkey = {$urandom, $urandom, $urandom, $urandom};
      run_key(rkey, (n % 2 == 1), $sformatf("rand%0d", n));
    end

    @(negedge clk);
    key_in    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    key_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    key_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_eq("midrst_flags", {125'h0, key_ready, busy, keys_valid}, 128'h4);
    read_rk(4'd1);
    check_eq("midrst_rk1", rk_out, 128'h0);
    read_rk(4'd0);
    check_eq("midrst_rk0", rk_out, 128'h0);
    @(negedge clk);
    rst = 1'b0;
    rkey = {$urandom, $urandom, $urandom, $urandom};
    run_key(rkey, 1'b0, "post_rst");

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/aes_key_expand.md
Name: aes_key_expand

Overview:
- Iterative AES-128 key schedule that sits directly upstream of the AES encryption datapath.
- Accepts a 128-bit cipher key through a valid/ready handshake and produces round keys 0..10, one per clock.
- Stores all 11 round keys in an internal register bank.
- The encryption datapath reads keys through a combinational index port once keys_valid is high.

Parameters:
- NR, 10, number of rounds. Fixed for AES-128; any other value is unsupported.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- key_in  input  128  cipher key; byte 0 = key_in[127:120]; word w0 = key_in[127:96]
- key_valid  input  1  key_in is valid this cycle
- key_ready  output  1  block can accept a key
- busy  output  1  expansion in progress
- keys_valid  output  1  all 11 round keys are stored and stable
- rk_idx  input  4  round key select, 0..10
- rk_out  output  128  round key rk_idx; words packed w[4i] at [127:96] down to w[4i+3] at [31:0]

Behaviour:
- Reset (asynchronous, rst=1):
  - state=IDLE, key_ready=1, busy=0, keys_valid=0.
  - All 11 stored keys cleared to 0; round counter=0.
- FSM states: IDLE, EXPAND, DONE.
- IDLE:
  - key_ready=1.
  - On key_valid&&key_ready: store key_in as rk[0], load working words w0..w3, set round=1, go to EXPAND.
- EXPAND:
  - key_ready=0, busy=1.
  - Each cycle computes rk[round] from the previous 4 words:
    - t = SubWord(RotWord(w3)) ^ {Rcon[round],24'h0}
    - n0 = w0^t, n1 = w1^n0, n2 = w2^n1, n3 = w3^n2
  - Stores {n0,n1,n2,n3} into rk[round]; working words <= n; round++.
  - On the cycle storing rk[10], go to DONE.
- RotWord: {w[23:0], w[31:24]}.
- SubWord: the AES forward S-box applied to each of the 4 bytes, combinational, 4 instances.
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36.
- DONE:
  - keys_valid=1, busy=0, key_ready=1.
  - On key_valid: keys_valid drops to 0 the next cycle, rk[0] reloads, go to EXPAND (rekey).
- Latency: handshake at edge E0. rk[i] is written at edge E0+i. keys_valid=1 after edge E0+10, so it is observable 10 cycles after the accept edge.
- rk_out:
  - Combinational read of rk[rk_idx], valid in any state; content is only guaranteed while keys_valid=1.
  - rk_idx > 10 returns 128'h0.
  - Intermediate keys may be read during EXPAND once written; consumers must not rely on this.
- key_valid while key_ready=0 (EXPAND) is ignored. No queueing; the upstream source must hold key_valid.
- keys_valid and busy are never both 1. key_ready = !busy.
- Reset mid-expansion aborts immediately: IDLE, all keys cleared, keys_valid=0.
- All arithmetic is bytewise XOR/substitution; no carries.

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c accepted:
  - rk[0]=the key; rk[1]=a0fafe1788542cb123a339392a6c7605; rk[10]=d014f9a8c9ee2589e13f0cc8b6630ca6.
  - keys_valid rises exactly 10 cycles after the accept edge.
- All-zero key:
  - rk[1]=62636363626363636263636362636363; rk[10]=b4ef5bcb3e92e21123e951cf6f8f188e.
- Protocol checks:
  - key_valid pulsed during EXPAND with a different key -> ignored; final keys match the first key; key_ready=0 throughout EXPAND.
  - rk_idx=11..15 -> rk_out=0; rk_idx=0 in DONE -> the original key.
- Rekey and reset:
  - Rekey from DONE with the zero key after the FIPS key -> keys_valid=0 the next cycle, 10 cycles later rk[10]=b4ef5b...188e.
  - rst asserted at round 5, asynchronously between edges -> all outputs at reset values before the next edge; rk[1] reads 0.
  - A subsequent key then expands correctly.
